// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
package prog_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive channel and memory write port of the loader.
interface prog_loader_if #(
    parameter int WIDTH = 32
);
    import prog_loader_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_ready;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_adr;
    logic [WIDTH-1:0]  mem_wdata;

    modport slave (
        input  rx_valid, rx_byte,
        output rx_ready, mem_we, mem_adr, mem_wdata
    );

    modport master (
        output rx_valid, rx_byte,
        input  rx_ready, mem_we, mem_adr, mem_wdata
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Collects four stream bytes MSB-first into one 32-bit word.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_shift,
    input  logic [BYTE_W-1:0]   i_byte,
    output logic [4*BYTE_W-1:0] o_word,
    output logic                o_last,
    output logic                o_full
);

    logic [4*BYTE_W-1:0] r_shift;
    logic [1:0]          r_count;
    logic                r_full;

    // Full goes high together with the fourth byte and stays until the next byte arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_shift) begin
            r_shift <= {r_shift[3*BYTE_W-1:0], i_byte};
            r_count <= r_count + 2'd1;
            r_full  <= (r_count == 2'd3);
        end
    end

    assign o_word = r_shift;
    assign o_last = (r_count == 2'd3);
    assign o_full = r_full;

endmodule

// File: rtl/prog_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes it into
// instruction memory, holding the core in reset until the image is good.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] BASE     = 32'h0,
    parameter int          MAXWORDS = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    prog_loader_if.slave   bus,
    output logic           cpu_reset,
    output logic           done,
    output logic           err
);

    localparam int CNT_W = $clog2(MAXWORDS + 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [LEN_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_wordCnt;
    logic [BYTE_W-1:0]   r_csum;

    logic                w_ready;
    logic                w_accept;
    logic                w_startLoad;
    logic [LEN_W-1:0]    w_lenFull;
    logic [31:0]         w_wordNext;
    logic [4*BYTE_W-1:0] w_word;
    logic                w_last;
    logic                w_full;

    assign w_ready     = (r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
    assign w_accept    = bus.rx_valid && w_ready;
    assign w_startLoad = start && (r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_lenFull   = {r_len[LEN_W-1:BYTE_W], bus.rx_byte};
    assign w_wordNext  = 32'(r_wordCnt) + 32'd1;

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_startLoad),
        .i_shift (w_accept && (r_state == S_DATA)),
        .i_byte  (bus.rx_byte),
        .o_word  (w_word),
        .o_last  (w_last),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_nextState = S_LEN_HI;
            S_LEN_HI: if (w_accept) w_nextState = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (32'(w_lenFull) > 32'(MAXWORDS)) w_nextState = S_ERR;
                    else if (w_lenFull == '0)            w_nextState = S_CSUM;
                    else                                 w_nextState = S_DATA;
                end
            end
            S_DATA:  if (w_accept && w_last) w_nextState = S_WRITE;
            S_WRITE: w_nextState = (w_wordNext < 32'(r_len)) ? S_DATA : S_CSUM;
            S_CSUM: begin
                if (w_accept) w_nextState = (bus.rx_byte == r_csum) ? S_DONE : S_ERR;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Length, word index and checksum restart with every new load; length bytes stay out of the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len     <= '0;
            r_wordCnt <= '0;
            r_csum    <= '0;
        end else if (w_startLoad) begin
            r_len     <= '0;
            r_wordCnt <= '0;
            r_csum    <= '0;
        end else begin
            case (r_state)
                S_LEN_HI: if (w_accept) r_len[LEN_W-1:BYTE_W] <= bus.rx_byte;
                S_LEN_LO: if (w_accept) r_len[BYTE_W-1:0]     <= bus.rx_byte;
                S_DATA:   if (w_accept) r_csum <= r_csum ^ bus.rx_byte;
                S_WRITE:  r_wordCnt <= r_wordCnt + 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        bus.rx_ready  = w_ready;
        bus.mem_we    = 1'b0;
        bus.mem_adr   = '0;
        bus.mem_wdata = '0;
        cpu_reset     = 1'b1;
        done          = 1'b0;
        err           = 1'b0;
        case (r_state)
            S_WRITE: begin
                bus.mem_we    = w_full;
                bus.mem_adr   = WIDTH'(BASE) + WIDTH'({r_wordCnt, 2'b00});
                bus.mem_wdata = WIDTH'(w_word);
            end
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random byte streams against a
// stream-level model of the load protocol.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] BASE     = 32'h0;
    localparam int          MAXWORDS = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_reset, done, err;

    prog_loader_if #(.WIDTH(WIDTH)) bus ();

    prog_loader #(.WIDTH(WIDTH), .BASE(BASE), .MAXWORDS(MAXWORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  stream[$];
    logic [31:0] expAdr[$], expData[$];
    logic [31:0] gotAdr[$], gotData[$];
    logic        gotReady[$];
    int          expConsumed;
    logic        expDone, expErr;

    // Every write strobe is captured mid-cycle, along with rx_ready in that same cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            gotAdr.push_back(bus.mem_adr);
            gotData.push_back(bus.mem_wdata);
            gotReady.push_back(bus.rx_ready);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Protocol-level model: length, words, xor of data bytes, outcome.
    task automatic modelLoad();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        expAdr.delete();
        expData.delete();
        n = int'({stream[0], stream[1]});
        if (n > MAXWORDS) begin
            expConsumed = 2;
            expDone = 1'b0;
            expErr = 1'b1;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                w = (w << 8) | 32'(stream[2 + 4*k + j]);
                x = x ^ stream[2 + 4*k + j];
            end
            expAdr.push_back(BASE + 32'(4 * k));
            expData.push_back(w);
        end
        expConsumed = 2 + 4*n + 1;
        expDone = (stream[2 + 4*n] == x);
        expErr = !expDone;
    endtask

    task automatic buildStream(input int n);
        logic [15:0] len;
        logic [7:0]  b, x;
        len = 16'(n);
        stream.delete();
        stream.push_back(len[15:8]);
        stream.push_back(len[7:0]);
        if (n <= MAXWORDS) begin
            x = 8'h00;
            for (int i = 0; i < 4*n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                stream.push_back(b);
            end
            stream.push_back(x);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit gaps, output bit ok);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rx_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic sendStream(input int count, input bit gaps, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < count && ok; i++) sendByte(stream[i], gaps, ok);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runLoad(input bit doStart, input bit gaps, output bit ok);
        gotAdr.delete();
        gotData.delete();
        gotReady.delete();
        modelLoad();
        if (doStart) pulseStart();
        sendStream(expConsumed, gaps, ok);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        vectors++;
        if ({bus.rx_ready, bus.mem_we, done, err, cpu_reset} !== 5'b00001 ||
            bus.mem_adr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset.outputs got rdy/we/done/err/cpurst=%b%b%b%b%b adr=%h wd=%h want 00001 0 0",
                     bus.rx_ready, bus.mem_we, done, err, cpu_reset, bus.mem_adr, bus.mem_wdata);
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({bus.rx_ready, done, err, cpu_reset} !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL reset.idle got rdy/done/err/cpurst=%b%b%b%b want 0001",
                     bus.rx_ready, done, err, cpu_reset);
        end
    endtask

    task automatic test_single_word();
        bit ok;
        stream = '{8'h00, 8'h01, 8'h8C, 8'h41, 8'h00, 8'h00, 8'hCD};
        runLoad(1'b1, 1'b0, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL single.handshake got timeout want accepted"); end
        vectors++;
        if (gotAdr.size() != 1 || gotAdr[0] !== 32'h0 || gotData[0] !== 32'h8C410000) begin
            miscompares++;
            $display("[TB] FAIL single.write got n=%0d adr=%h wd=%h want n=1 adr=0 wd=8c410000",
                     gotAdr.size(), (gotAdr.size() > 0) ? gotAdr[0] : 32'hx, (gotData.size() > 0) ? gotData[0] : 32'hx);
        end
        vectors++;
        if ({done, err, cpu_reset} !== {expDone, expErr, !expDone}) begin
            miscompares++;
            $display("[TB] FAIL single.status got done/err/cpurst=%b%b%b want %b%b%b",
                     done, err, cpu_reset, expDone, expErr, !expDone);
        end
    endtask

    task automatic test_three_words();
        bit ok;
        buildStream(3);
        runLoad(1'b1, 1'b1, ok);
        vectors++;
        if (!ok || gotAdr.size() != expAdr.size()) begin
            miscompares++;
            $display("[TB] FAIL three.count got ok=%0b n=%0d want ok=1 n=%0d", ok, gotAdr.size(), expAdr.size());
        end
        foreach (expAdr[i]) begin
            if (i < gotAdr.size()) begin
                vectors++;
                if (gotAdr[i] !== expAdr[i] || gotData[i] !== expData[i] || gotReady[i] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL three.word%0d got adr=%h wd=%h rdy=%b want adr=%h wd=%h rdy=0",
                             i, gotAdr[i], gotData[i], gotReady[i], expAdr[i], expData[i]);
                end
            end
        end
        vectors++;
        if ({done, err} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL three.status got done/err=%b%b want 10", done, err);
        end
    endtask

    task automatic test_bad_checksum();
        bit ok;
        stream = '{8'h00, 8'h01, 8'h8C, 8'h41, 8'h00, 8'h00, 8'h00};
        runLoad(1'b1, 1'b0, ok);
        vectors++;
        if (!ok || {done, err, cpu_reset} !== {expDone, expErr, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL badsum.status got ok=%0b done/err/cpurst=%b%b%b want 1 %b%b1",
                     ok, done, err, cpu_reset, expDone, expErr);
        end
        buildStream(1);
        runLoad(1'b1, 1'b1, ok);
        vectors++;
        if (!ok || {done, err, cpu_reset} !== {expDone, expErr, 1'b0} ||
            gotData.size() != 1 || gotData[0] !== expData[0]) begin
            miscompares++;
            $display("[TB] FAIL badsum.recover got ok=%0b done/err/cpurst=%b%b%b n=%0d want 1 %b%b0 n=1",
                     ok, done, err, cpu_reset, gotData.size(), expDone, expErr);
        end
    endtask

    task automatic test_length_limits();
        bit ok;
        buildStream(MAXWORDS + 1);
        runLoad(1'b1, 1'b0, ok);
        vectors++;
        if (!ok || {done, err} !== {expDone, expErr} || gotAdr.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL limits.over got ok=%0b done/err=%b%b writes=%0d want 1 %b%b 0",
                     ok, done, err, gotAdr.size(), expDone, expErr);
        end
        stream = '{8'h00, 8'h00, 8'h00};
        runLoad(1'b1, 1'b0, ok);
        vectors++;
        if (!ok || {done, err} !== {expDone, expErr} || gotAdr.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL limits.zero got ok=%0b done/err=%b%b writes=%0d want 1 %b%b 0",
                     ok, done, err, gotAdr.size(), expDone, expErr);
        end
        buildStream(MAXWORDS);
        runLoad(1'b1, 1'b0, ok);
        vectors++;
        if (!ok || done !== expDone || gotAdr.size() != expAdr.size() ||
            gotAdr[gotAdr.size()-1] !== expAdr[expAdr.size()-1] ||
            gotData[gotData.size()-1] !== expData[expData.size()-1]) begin
            miscompares++;
            $display("[TB] FAIL limits.max got ok=%0b done=%b n=%0d want 1 %b n=%0d last adr=%h",
                     ok, done, gotAdr.size(), expDone, expAdr.size(), expAdr[expAdr.size()-1]);
        end
    endtask

    task automatic test_reload();
        bit ok;
        buildStream(2);
        runLoad(1'b1, 1'b0, ok);
        start = 1'b1;
        #3;
        vectors++;
        if ({done, cpu_reset} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reload.before got done/cpurst=%b%b want 10", done, cpu_reset);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if ({done, cpu_reset, bus.rx_ready} !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL reload.after got done/cpurst/rdy=%b%b%b want 011", done, cpu_reset, bus.rx_ready);
        end
        buildStream(2);
        runLoad(1'b0, 1'b1, ok);
        vectors++;
        if (!ok || done !== 1'b1 || gotAdr.size() != 2 || gotAdr[0] !== BASE || gotData[1] !== expData[1]) begin
            miscompares++;
            $display("[TB] FAIL reload.second got ok=%0b done=%b n=%0d adr0=%h want 1 1 2 %h",
                     ok, done, gotAdr.size(), (gotAdr.size() > 0) ? gotAdr[0] : 32'hx, BASE);
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        buildStream(2);
        gotAdr.delete();
        gotData.delete();
        gotReady.delete();
        pulseStart();
        sendStream(4, 1'b0, ok);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (!ok || {bus.rx_ready, bus.mem_we, done, err, cpu_reset} !== 5'b00001) begin
            miscompares++;
            $display("[TB] FAIL midreset.async got ok=%0b rdy/we/done/err/cpurst=%b%b%b%b%b want 1 00001",
                     ok, bus.rx_ready, bus.mem_we, done, err, cpu_reset);
        end
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'($urandom);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        vectors++;
        if (gotAdr.size() != 0 || {bus.rx_ready, cpu_reset} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL midreset.quiet got writes=%0d rdy/cpurst=%b%b want 0 01",
                     gotAdr.size(), bus.rx_ready, cpu_reset);
        end
    endtask

    task automatic test_random_loads();
        bit ok;
        for (int t = 0; t < 6; t++) begin
            buildStream($urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) stream[stream.size()-1] = stream[stream.size()-1] ^ 8'($urandom_range(1, 255));
            runLoad(1'b1, 1'b1, ok);
            vectors++;
            if (!ok || {done, err, cpu_reset} !== {expDone, expErr, !expDone} || gotAdr.size() != expAdr.size()) begin
                miscompares++;
                $display("[TB] FAIL random%0d.status got ok=%0b done/err/cpurst=%b%b%b n=%0d want 1 %b%b%b n=%0d",
                         t, ok, done, err, cpu_reset, gotAdr.size(), expDone, expErr, !expDone, expAdr.size());
            end
            foreach (expAdr[i]) begin
                if (i < gotAdr.size()) begin
                    vectors++;
                    if (gotAdr[i] !== expAdr[i] || gotData[i] !== expData[i]) begin
                        miscompares++;
                        $display("[TB] FAIL random%0d.word%0d got adr=%h wd=%h want adr=%h wd=%h",
                                 t, i, gotAdr[i], gotData[i], expAdr[i], expData[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        test_reset();
        test_single_word();
        test_three_words();
        test_bad_checksum();
        test_length_limits();
        test_reload();
        test_reset_midload();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the memory data and address width in bits.
REQ-002 SHALL have parameter BASE, default 32'h0, meaning the byte address of the first loaded word.
REQ-003 SHALL have parameter MAXWORDS, default 256, meaning the largest legal word count.
REQ-004 SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, width 1: one clock; reset is asynchronous and active-low (asserted at 0).
REQ-006 SHALL have port start, input, width 1, a request to begin a load.
REQ-007 SHALL have port rx_valid, input, width 1, meaning rx_byte is valid.
REQ-008 SHALL have port rx_byte, input, width 8, the incoming stream byte.
REQ-009 SHALL have port rx_ready, output, width 1, meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we, output, width 1, the instruction/data memory write strobe.
REQ-011 SHALL have port mem_adr, output, width WIDTH, the byte address of the write.
REQ-012 SHALL have port mem_wdata, output, width WIDTH, the word being written.
REQ-013 SHALL have port cpu_reset, output, width 1, active-high reset for the downstream mips32 core.
REQ-014 SHALL have port done, output, width 1, meaning the load completed with a good checksum.
REQ-015 SHALL have port err, output, width 1, meaning the load failed.

Function
REQ-016 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR.
REQ-017 SHALL accept a byte only on a rising edge where rx_valid=1 and rx_ready=1.
REQ-018 SHALL drive rx_ready=1 only in LEN_HI, LEN_LO, DATA and CSUM.
REQ-019 SHALL move IDLE->LEN_HI when start=1, and stay in IDLE otherwise.
REQ-020 SHALL take the word count N as 16 bits, big-endian: LEN_HI->LEN_LO after accepting the high byte, then LEN_LO on accepting the low byte.
REQ-021 SHALL leave LEN_LO for ERR if N>MAXWORDS, for CSUM if N=0, and for DATA otherwise.
REQ-022 SHALL assemble each word from 4 bytes, MSB first (first byte -> bits 31:24), matching the IR byte order.
REQ-023 SHALL, after the 4th byte, spend exactly one cycle in WRITE with mem_we=1, mem_adr=BASE+4*k (k = word index from 0) and mem_wdata = the assembled word.
REQ-024 SHALL drive mem_we=0 in every state other than WRITE.
REQ-025 SHALL go WRITE->DATA if k+1<N, and WRITE->CSUM when k+1=N.
REQ-026 SHALL keep a running checksum equal to the XOR of all data bytes only (not the length bytes), cleared on entry to LEN_HI.
REQ-027 SHALL, in CSUM, go to DONE on accepting a byte equal to the checksum, and to ERR otherwise.
REQ-028 SHALL hold cpu_reset=1 in all states except DONE, where cpu_reset=0.
REQ-029 SHALL drive done=1 only in DONE and err=1 only in ERR.
REQ-030 SHALL move DONE->LEN_HI and ERR->LEN_HI when start=1; cpu_reset rises in the same cycle the state changes.
REQ-031 SHALL ignore start in LEN_HI through CSUM.
REQ-032 SHALL not time out: a stalled rx_valid holds the current state indefinitely.
REQ-033 SHALL keep the address counter wide enough for MAXWORDS, so the address never wraps within a legal load.

Reset
REQ-034 SHALL, while reset=0, asynchronously force state=IDLE, rx_ready=0, mem_we=0, mem_adr=0, mem_wdata=0, done=0, err=0, cpu_reset=1, and clear the word counter, byte counter and checksum.
REQ-035 SHALL, on reset asserted mid-load, abandon the load with no further mem_we pulses; the partial memory contents are undefined.

Structure
REQ-036 SHALL take the state encodings, the 8-bit byte width constant and the 16-bit length width constant from a shared package, prog_loader_pkg.
REQ-037 SHALL use exactly one sub-module, word_assembler: a 4-byte shift register with a 2-bit byte counter and a "full" flag.

Verification
REQ-038 SHALL test a single word: start, then bytes 00 01 8C 41 00 00 -> one mem_we pulse at adr 0x0 with wdata 0x8C410000, checksum byte 0xCD accepted, done=1, cpu_reset=0.
REQ-039 SHALL test three words with random rx_valid gaps -> mem_we at 0x0, 0x4 and 0x8 with the correct words, rx_ready=0 in each WRITE cycle, done=1.
REQ-040 SHALL test a bad checksum: a one-word load with checksum byte 0x00 -> err=1, done=0, cpu_reset stays 1; then start and a good load -> done=1.
REQ-041 SHALL test length limits: N=0x0101 (257) -> err=1 and no mem_we; N=0 with checksum 0x00 -> done=1 and no mem_we.
REQ-042 SHALL test reset mid-load: reset=0 after 2 data bytes -> IDLE immediately (asynchronously), cpu_reset=1 and no mem_we thereafter.
REQ-043 SHALL test a reload: start in DONE -> cpu_reset=1 on the next edge, and a second load writes from BASE again.
